// File: rtl/phy_arb_pkg.sv
// Shared types and constants for the PHY transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter state enum, word layout, idle word, counter widths,
// one-hot to index helper.
package phy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP,
    GAP
  } arb_state_t;

  localparam int WORD_W    = 9;
  localparam int TX_EN_BIT = 8;
  localparam logic [WORD_W-1:0] IDLE_WORD = 9'h000;

  // Word counter must hold MAX_FRAME (<= 2047); gap counter holds IFG_WORDS-2.
  localparam int WCNT_W = 11;
  localparam int GCNT_W = 8;
  localparam int STAT_W = 16;

  // Index of the set bit of a one-hot vector of up to 8 sources.
  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/phy_arb_rr_pick.sv
// Round-robin picker: first requester after last_idx, wrapping around.
// Latency: combinational.
// Backpressure: none; vld low when no request is present.
// Ports: req (request vector), last_idx (last granted index),
//        gnt (one-hot pick), vld (any pick made).
module phy_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_idx) + i) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Frame-level scheduler copying whole frames from NUM_SRC source FIFOs into one PHY FIFO.
// Latency: candidate at t -> grant at t+1 -> phy_wr_en at t+2; then one word per cycle.
// Backpressure: phy_full (>=2 words slack) stalls pop and write; empty granted source stalls.
// Ports: pcie_clk/sys_rst_n (clock, async active-low reset); src_empty/src_dout/src_rd_en
//        (FWFT source FIFOs, 9-bit {tx_en,data} words); phy_din/phy_wr_en/phy_full (PHY FIFO);
//        grant, busy, frame_cnt, trunc_cnt (status).
// Build option: define PHY_ARB_PRIO_EN to give source 0 strict priority in IDLE.
module phy_tx_arbiter
  import phy_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int IFG_WORDS = 12,
  parameter int MAX_FRAME = 1522
) (
  input  logic                      pcie_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_SRC-1:0]        src_empty,
  input  logic [WORD_W*NUM_SRC-1:0] src_dout,
  output logic [NUM_SRC-1:0]        src_rd_en,
  output logic [WORD_W-1:0]         phy_din,
  input  logic                      phy_full,
  output logic                      phy_wr_en,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy,
  output logic [STAT_W-1:0]         frame_cnt,
  output logic [STAT_W-1:0]         trunc_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    g_q, g_d, last_q, last_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [STAT_W-1:0]   frame_q, frame_d, trunc_q, trunc_d;
  logic                wr_q, wr_d;
  logic [WORD_W-1:0]   din_q, din_d;

  logic [NUM_SRC-1:0]  head_tx, cand, stray, stray_oh;
  logic [NUM_SRC-1:0]  pick_req, pick_gnt, sel_oh, rd;
  logic                pick_vld, any_cand;
  logic [WORD_W-1:0]   head;
  logic                g_empty;

  always_comb begin
    head_tx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      head_tx[i] = src_dout[WORD_W*i + TX_EN_BIT];
    end
  end

  assign cand     = ~src_empty & head_tx;
  assign stray    = ~src_empty & ~head_tx;
  // Isolate the lowest set bit so only one stray word is dropped per cycle.
  assign stray_oh = stray & (~stray + NUM_SRC'(1));

`ifdef PHY_ARB_PRIO_EN
  // Source 0 bypasses the rotation; the picker only sees sources 1..N-1.
  assign pick_req = cand & ~NUM_SRC'(1);
  assign sel_oh   = cand[0] ? NUM_SRC'(1) : pick_gnt;
  assign any_cand = cand[0] | pick_vld;
`else
  assign pick_req = cand;
  assign sel_oh   = pick_gnt;
  assign any_cand = pick_vld;
`endif

  phy_arb_rr_pick #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_pick (
    .req      (pick_req),
    .last_idx (last_q),
    .gnt      (pick_gnt),
    .vld      (pick_vld)
  );

  assign head    = src_dout[int'(g_q)*WORD_W +: WORD_W];
  assign g_empty = src_empty[g_q];

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    grant_d = grant_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    frame_d = frame_q;
    trunc_d = trunc_q;
    wr_d    = 1'b0;
    din_d   = IDLE_WORD;
    rd      = '0;

    unique case (state_q)
      IDLE: begin
        rd = stray_oh;
        if (any_cand) begin
          grant_d = sel_oh;
          g_d     = IDX_W'(oh_to_idx(8'(sel_oh)));
          wcnt_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!phy_full && !g_empty) begin
          wr_d = 1'b1;
          if (head[TX_EN_BIT] && wcnt_q == WCNT_W'(MAX_FRAME)) begin
            // Over-length: close the frame on the wire, leave the head for DROP.
            din_d   = IDLE_WORD;
            trunc_d = trunc_q + 1'b1;
            state_d = DROP;
          end else begin
            rd[g_q] = 1'b1;
            din_d   = head;
            if (!head[TX_EN_BIT]) begin
              gcnt_d  = GCNT_W'(IFG_WORDS - 2);
              frame_d = frame_q + 1'b1;
              state_d = GAP;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!g_empty) begin
          rd[g_q] = 1'b1;
          if (!head[TX_EN_BIT]) begin
            gcnt_d  = GCNT_W'(IFG_WORDS - 2);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!phy_full) begin
          wr_d = 1'b1;
          if (gcnt_q == '0) begin
            grant_d = '0;
            state_d = IDLE;
`ifdef PHY_ARB_PRIO_EN
            // Source 0 does not take part in the rotation of 1..N-1.
            if (g_q != '0) last_d = g_q;
`else
            last_d = g_q;
`endif
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      grant_q <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      frame_q <= '0;
      trunc_q <= '0;
      wr_q    <= 1'b0;
      din_q   <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      frame_q <= frame_d;
      trunc_q <= trunc_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
    end
  end

  // Pops are combinational; hold them off while reset is asserted.
  assign src_rd_en = sys_rst_n ? rd : '0;
  assign phy_din   = din_q;
  assign phy_wr_en = wr_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_q;
  assign trunc_cnt = trunc_q;

endmodule
